// File: rtl/input_conditioner.sv
// Synchronises and debounces raw buttons/switches, emitting one-cycle press/release/change pulses.
// Optional latched press flags (btn_sticky_o/sticky_clear_i) are built when BTN_STICKY_EN is defined.
module input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [N_BTN-1:0] buttons_raw_i,
  input  logic [N_SW-1:0]  switches_raw_i,
`ifdef BTN_STICKY_EN
  input  logic [N_BTN-1:0] sticky_clear_i,
  output logic [N_BTN-1:0] btn_sticky_o,
`endif
  output logic [N_BTN-1:0] buttons_o,
  output logic [N_SW-1:0]  switches_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic             sw_changed_o
);

  localparam int N_TOT = N_BTN + N_SW;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_TOT-1:0] raw;
  logic [N_TOT-1:0] sync1_q, sync2_q;
  logic [N_TOT-1:0] stable_q, stable_d, chg;
  logic [CNT_W-1:0] cnt_q [N_TOT];
  logic [CNT_W-1:0] cnt_d [N_TOT];
  logic [N_BTN-1:0] press_q, press_d, release_q, release_d;
  logic             swc_q, swc_d;

  // Buttons occupy the low bits, switches the high bits; every bit is debounced alike.
  assign raw = {switches_raw_i, buttons_raw_i};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_TOT; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
    chg       = stable_d ^ stable_q;
    press_d   = chg[N_BTN-1:0] & stable_d[N_BTN-1:0];
    release_d = chg[N_BTN-1:0] & ~stable_d[N_BTN-1:0];
    swc_d     = |chg[N_TOT-1:N_BTN];
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      swc_q     <= 1'b0;
      for (int i = 0; i < N_TOT; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      swc_q     <= swc_d;
      for (int i = 0; i < N_TOT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign buttons_o     = stable_q[N_BTN-1:0];
  assign switches_o    = stable_q[N_TOT-1:N_BTN];
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign sw_changed_o  = swc_q;

`ifdef BTN_STICKY_EN
  logic [N_BTN-1:0] sticky_q, sticky_d;

  // A press arriving with a clear wins, so no press is ever lost.
  assign sticky_d = (sticky_q & ~sticky_clear_i) | press_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) sticky_q <= '0;
    else           sticky_q <= sticky_d;
  end

  assign btn_sticky_o = sticky_q;
`endif

endmodule
